// File: rtl/mic_volume_meter_if.sv
// +--------------------------------------------------------------------------+
// | mic_volume_meter_if : sample stream in, volume-level results out          |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

interface mic_volume_meter_if;
   logic        sample_valid;
   logic [11:0] sample;
   logic        clear;
   logic [10:0] peak_amp;
   logic [3:0]  level_raw;
   logic [3:0]  level_peak;
   logic        level_valid;

   // master: the sample source that also consumes the levels
   modport master (
      output sample_valid,
      output sample,
      output clear,
      input  peak_amp,
      input  level_raw,
      input  level_peak,
      input  level_valid
   );

   modport slave (
      input  sample_valid,
      input  sample,
      input  clear,
      output peak_amp,
      output level_raw,
      output level_peak,
      output level_valid
   );
endinterface

`default_nettype wire

// File: rtl/mic_volume_meter.sv
// +--------------------------------------------------------------------------+
// | mic_volume_meter : windowed peak amplitude, 4-bit level, peak-hold decay  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module mic_volume_meter #(
   parameter int WINDOW        = 2000,
   parameter int DECAY_WINDOWS = 2,
   parameter int MIDPOINT      = 2048
) (
   input  logic              basys_clk,
   input  logic              rst_n,
   mic_volume_meter_if.slave bus
);

   localparam int               CNT_W      = (WINDOW > 2) ? $clog2(WINDOW) : 1;
   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WINDOW - 1);
   localparam logic [12:0]      c_MID      = 13'(MIDPOINT);
   localparam logic [12:0]      c_AMP_MAX  = 13'd2047;
   localparam logic [8:0]       c_DECAY    = 9'(DECAY_WINDOWS);

   logic [10:0]      acc_q,         acc_d;
   logic [CNT_W-1:0] cnt_q,         cnt_d;
   logic [7:0]       dcnt_q,        dcnt_d;
   logic [10:0]      peak_amp_q,    peak_amp_d;
   logic [3:0]       level_raw_q,   level_raw_d;
   logic [3:0]       level_peak_q,  level_peak_d;
   logic             level_valid_q, level_valid_d;

   logic [12:0] w_sample_ext;
   logic [12:0] w_diff;
   logic [10:0] w_amp;
   logic [10:0] w_final;
   logic [3:0]  w_level;
   logic [3:0]  w_peak_dec;
   logic [8:0]  w_dcnt_inc;

   // A full-scale negative sample gives a magnitude of 2048, which does not fit 11 bits
   assign w_sample_ext = {1'b0, bus.sample};
   assign w_diff       = (w_sample_ext >= c_MID) ? (w_sample_ext - c_MID) : (c_MID - w_sample_ext);
   assign w_amp        = (w_diff > c_AMP_MAX) ? 11'h7FF : w_diff[10:0];

   assign w_final      = (w_amp > acc_q) ? w_amp : acc_q;
   assign w_level      = w_final[10:7];
   assign w_peak_dec   = ((level_peak_q - 4'd1) > w_level) ? (level_peak_q - 4'd1) : w_level;
   assign w_dcnt_inc   = {1'b0, dcnt_q} + 9'd1;

   always_comb begin
      acc_d         = acc_q;
      cnt_d         = cnt_q;
      dcnt_d        = dcnt_q;
      peak_amp_d    = peak_amp_q;
      level_raw_d   = level_raw_q;
      level_peak_d  = level_peak_q;
      level_valid_d = 1'b0;

      if (bus.clear) begin
         acc_d        = '0;
         cnt_d        = '0;
         dcnt_d       = '0;
         level_peak_d = '0;
      end else if (bus.sample_valid) begin
         if (cnt_q == c_CNT_LAST) begin
            peak_amp_d    = w_final;
            level_raw_d   = w_level;
            acc_d         = '0;
            cnt_d         = '0;
            level_valid_d = 1'b1;
            // Peak hold: rise immediately, fall one step after DECAY_WINDOWS quieter windows
            if (w_level >= level_peak_q) begin
               level_peak_d = w_level;
               dcnt_d       = '0;
            end else if (w_dcnt_inc == c_DECAY) begin
               level_peak_d = w_peak_dec;
               dcnt_d       = '0;
            end else begin
               dcnt_d = w_dcnt_inc[7:0];
            end
         end else begin
            acc_d = w_final;
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge basys_clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q         <= '0;
         cnt_q         <= '0;
         dcnt_q        <= '0;
         peak_amp_q    <= '0;
         level_raw_q   <= '0;
         level_peak_q  <= '0;
         level_valid_q <= 1'b0;
      end else begin
         acc_q         <= acc_d;
         cnt_q         <= cnt_d;
         dcnt_q        <= dcnt_d;
         peak_amp_q    <= peak_amp_d;
         level_raw_q   <= level_raw_d;
         level_peak_q  <= level_peak_d;
         level_valid_q <= level_valid_d;
      end
   end

   assign bus.peak_amp    = peak_amp_q;
   assign bus.level_raw   = level_raw_q;
   assign bus.level_peak  = level_peak_q;
   assign bus.level_valid = level_valid_q;

endmodule

`default_nettype wire

// File: doc/mic_volume_meter.md
MIC_VOLUME_METER -- requirements
Module: mic_volume_meter

Interface
REQ-001 Parameter WINDOW, default 2000: number of accepted samples per measurement window (100 ms at 20 kHz); legal range 2..65535.
REQ-002 Parameter DECAY_WINDOWS, default 2: consecutive lower-level windows before level_peak drops by 1; legal range 1..255.
REQ-003 Parameter MIDPOINT, default 2048: 12-bit zero-signal code of the microphone ADC.
REQ-004 basys_clk  input  1  system clock (100 MHz); all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset; release is synchronous to basys_clk.
REQ-006 sample_valid  input  1  single-cycle strobe, one per new microphone sample (20 kHz rate).
REQ-007 sample  input  12  raw microphone sample from the audio capture stage; meaningful only when sample_valid=1.
REQ-008 clear  input  1  synchronous clear of the window and the peak-hold state.
REQ-009 peak_amp  output  11  maximum amplitude of the last completed window.
REQ-010 level_raw  output  4  volume level of the last completed window.
REQ-011 level_peak  output  4  peak-hold volume level with decay; this feeds the game logic and the LED display.
REQ-012 level_valid  output  1  one-cycle strobe marking an update of peak_amp, level_raw and level_peak.

Function
REQ-013 Amplitude per accepted sample: amp = sample-MIDPOINT when sample>=MIDPOINT, else MIDPOINT-sample; saturate to 2047; width 11 bits.
REQ-014 A sample is accepted only on a cycle where sample_valid=1 and clear=0.
REQ-015 Internal window state: sample counter cnt (0..WINDOW-1) and running maximum acc (11 bits).
REQ-016 Accepting a sample with cnt<WINDOW-1: acc<=max(acc,amp); cnt<=cnt+1.
REQ-017 Accepting a sample with cnt==WINDOW-1 closes the window on the same edge:
  - final=max(acc,amp);
  - peak_amp<=final;
  - level_raw<=final[10:7];
  - acc<=0 and cnt<=0;
  - level_valid<=1 for exactly the following cycle.
  Latency from the closing sample_valid to the outputs is 1 cycle.
REQ-018 Peak-hold rule, applied on the window-closing edge with L=final[10:7]:
  - If L>=level_peak: level_peak<=L and decay counter dcnt<=0.
  - Else if dcnt+1==DECAY_WINDOWS: level_peak<=max(level_peak-1,L) and dcnt<=0.
  - Else dcnt<=dcnt+1.
REQ-019 level_peak changes by at most 1 per window when falling; it never falls below the level_raw of the same window.
REQ-020 level_valid is 0 on every cycle other than the cycle after a window close.
REQ-021 peak_amp, level_raw and level_peak hold their values between window closes.
REQ-022 clear=1:
  - acc<=0, cnt<=0, dcnt<=0, level_peak<=0;
  - peak_amp and level_raw hold their values;
  - no level_valid is generated;
  - clear takes precedence over a simultaneous sample_valid, and that sample is discarded.
REQ-023 sample_valid asserted on consecutive cycles: each cycle counts as a separate sample, with no loss.
REQ-024 sample is ignored when sample_valid=0.

Reset
REQ-025 rst_n=0 asynchronously forces peak_amp=0, level_raw=0, level_peak=0, level_valid=0, acc=0, cnt=0, dcnt=0.
REQ-026 Reset asserted mid-window discards the partial window; the first accepted sample after release is sample 1 of a new window.
REQ-027 Outputs stay at their reset values until the first window closes after release.

Verification
REQ-028 Parameters WINDOW=4, DECAY_WINDOWS=2. The bench shall cover these directed scenarios:
  - Samples 2048,2560,2048,2048 -> 1 cycle after the 4th strobe: level_valid=1, peak_amp=512, level_raw=4, level_peak=4.
  - Samples 0 and 4095 in one window -> peak_amp=2047 (saturation), level_raw=15.
  - After a window with level 15, four windows of all-2048 samples -> level_peak sequence 15,14,14,13 (drops on the 2nd and 4th windows); level_raw=0 on each.
  - clear pulsed coincident with the 2nd sample_valid of a window -> that sample is not counted, level_peak=0, and level_valid appears only after 4 further accepted samples.
  - rst_n pulled low after 3 samples of a window, then released -> all outputs 0; the next level_valid follows the 4th post-reset sample.
  - Strobes on 4 consecutive clock cycles with samples 3072,2048,2048,2048 -> exactly one level_valid, peak_amp=1024, level_raw=8.
